// File: rtl/stream_arb_pkg.sv
// Shared types for the round-robin stream arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package stream_arb_pkg;

  // IDLE arbitrates freely; LOCKED holds the grant until the packet's last beat.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/onehot_to_bin.sv
// One-hot to binary encoder for the arbiter grant vector.
// Latency: purely combinational, zero cycles.
// Backpressure: none; an all-zero input encodes to 0.
module onehot_to_bin #(
  parameter int unsigned ONEHOT_WIDTH = 4,
  parameter int unsigned BIN_WIDTH    = (ONEHOT_WIDTH == 1) ? 1 : $clog2(ONEHOT_WIDTH)
) (
  input  logic [ONEHOT_WIDTH-1:0] onehot_i,
  output logic [BIN_WIDTH-1:0]    bin_o
);

  // OR together the indices of set bits; exact when at most one bit is set.
  always_comb begin
    bin_o = '0;
    for (int unsigned i = 0; i < ONEHOT_WIDTH; i++) begin
      if (onehot_i[i]) begin
        bin_o = bin_o | BIN_WIDTH'(i);
      end
    end
  end

  // The encoding is only meaningful for a one-hot or empty input.
  always_comb begin
    onehot_in_chk : assert final ($onehot0(onehot_i));
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin merge of NumIn valid/ready streams with packet lock.
// Latency: zero cycles; valid/data/ready paths are combinational.
// Backpressure: ready_i passes straight to the granted input; a stalled beat locks the grant.
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int unsigned NumIn     = 4,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdxWidth  = (NumIn == 1) ? 1 : $clog2(NumIn)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic [NumIn-1:0]           valid_i,
  input  logic [NumIn-1:0]           last_i,
  input  logic [NumIn*DataWidth-1:0] data_i,
  output logic [NumIn-1:0]           ready_o,
  output logic                       valid_o,
  output logic                       last_o,
  output logic [DataWidth-1:0]       data_o,
  output logic [IdxWidth-1:0]        idx_o,
  input  logic                       ready_i
);

  arb_state_e          state_q, state_d;
  logic [IdxWidth-1:0] prio_q, prio_d;
  logic [IdxWidth-1:0] lock_q, lock_d;

  logic [NumIn-1:0]    prio_mask;
  logic [2*NumIn-1:0]  req_dbl;
  logic [NumIn-1:0]    rr_gnt;
  logic                rr_found;
  logic [NumIn-1:0]    lock_oh;
  logic [NumIn-1:0]    gnt;
  logic                hs;

  // Rotating priority: masked copy (>= prio_q) in the low half wins over the
  // unmasked wrap-around copy in the high half; lowest set bit is the winner.
  always_comb begin
    for (int unsigned k = 0; k < NumIn; k++) begin
      prio_mask[k] = (k >= 32'(prio_q));
    end
    req_dbl  = {valid_i, valid_i & prio_mask};
    rr_gnt   = '0;
    rr_found = 1'b0;
    for (int unsigned i = 0; i < 2 * NumIn; i++) begin
      if (!rr_found && req_dbl[i]) begin
        rr_found           = 1'b1;
        rr_gnt[i % NumIn]  = 1'b1;
      end
    end
  end

  // Final grant: nothing during reset/flush, the locked input while LOCKED.
  always_comb begin
    lock_oh         = '0;
    lock_oh[lock_q] = 1'b1;
    gnt             = '0;
    if (!(rst_i || flush_i)) begin
      if (state_q == LOCKED) begin
        gnt = lock_oh & valid_i;
      end else begin
        gnt = rr_gnt;
      end
    end
  end

  onehot_to_bin #(
    .ONEHOT_WIDTH (NumIn),
    .BIN_WIDTH    (IdxWidth)
  ) u_gnt_enc (
    .onehot_i (gnt),
    .bin_o    (idx_o)
  );

  // Output mux driven by the grant; an empty grant yields all-zero outputs.
  always_comb begin
    ready_o = gnt & {NumIn{ready_i}};
    valid_o = |gnt;
    last_o  = |(gnt & last_i);
    data_o  = '0;
    for (int unsigned k = 0; k < NumIn; k++) begin
      if (gnt[k]) begin
        data_o = data_o | data_i[k*DataWidth +: DataWidth];
      end
    end
    hs = valid_o & ready_i;
  end

  // Packet tracking: lock on stall or non-last beat, release and rotate on last handshake.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    lock_d  = lock_q;
    if (rst_i || flush_i) begin
      state_d = IDLE;
      prio_d  = '0;
      lock_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_o && (!ready_i || !last_o)) begin
            state_d = LOCKED;
            lock_d  = idx_o;
          end
        end
        LOCKED: begin
          if (hs && last_o) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      if (hs && last_o) begin
        prio_d = (idx_o == IdxWidth'(NumIn - 1)) ? '0 : idx_o + IdxWidth'(1);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      prio_q  <= '0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      lock_q  <= lock_d;
    end
  end

  ready_onehot_chk : assert property (@(posedge clk_i) $onehot0(ready_o));
  data_stable_chk  : assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
                                      (valid_o && !ready_i) |=> $stable(data_o));
  lock_gnt_chk     : assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
                                      (state_q == LOCKED) |-> (gnt == '0 || gnt == lock_oh));
  lock_valid_chk   : assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
                                      (state_q == LOCKED) |-> valid_i[lock_q]);

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter with an expected-beat scoreboard.
// Latency: checks outputs 1 ns after each input change, mid low phase.
// Backpressure: ready_i driven directly by the stimulus steps.
module tb_stream_rr_arbiter;

  logic         clk_i;
  logic         rst_i;
  logic         flush_i;
  logic [3:0]   valid_i;
  logic [3:0]   last_i;
  logic [127:0] data_i;
  logic [3:0]   ready_o;
  logic         valid_o;
  logic         last_o;
  logic [31:0]  data_o;
  logic [1:0]   idx_o;
  logic         ready_i;

  typedef struct packed {
    logic [1:0]  idx;
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t      exp_q[$];
  int         n_pass;
  int         n_total;
  logic [7:0] cur_seed;

  stream_rr_arbiter #(
    .NumIn     (4),
    .DataWidth (32)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .last_i  (last_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .last_o  (last_o),
    .data_o  (data_o),
    .idx_o   (idx_o),
    .ready_i (ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] lane_data(input int k, input logic [7:0] seed);
    return {4'hA, 4'(k), 16'h5A5A, seed};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic r,
                       input logic [7:0] seed);
    valid_i  = v;
    last_i   = l;
    ready_i  = r;
    cur_seed = seed;
    for (int k = 0; k < 4; k++) begin
      data_i[k*32 +: 32] = lane_data(k, seed);
    end
  endtask

  task automatic push(input int idx, input logic l);
    beat_t b;
    b.idx  = 2'(idx);
    b.data = lane_data(idx, cur_seed);
    b.last = l;
    exp_q.push_back(b);
  endtask

  // Compare the current cycle against the scoreboard, then advance one clock.
  task automatic cycle(input string tag);
    logic       hs;
    logic       want;
    logic [3:0] er;
    beat_t      e;
    #1;
    hs   = valid_o & ready_i;
    want = (exp_q.size() != 0);
    er   = want ? (4'b0001 << exp_q[0].idx) : 4'b0000;
    check({tag, ".ready_o"}, 64'(ready_o), 64'(er));
    check({tag, ".handshake"}, 64'(hs), 64'(want));
    if (want) begin
      e = exp_q.pop_front();
      check({tag, ".idx_o"}, 64'(idx_o), 64'(e.idx));
      check({tag, ".data_o"}, 64'(data_o), 64'(e.data));
      check({tag, ".last_o"}, 64'(last_o), 64'(e.last));
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;

    // Reset with every input requesting: all outputs must stay zero.
    rst_i   = 1'b1;
    flush_i = 1'b0;
    drive(4'b1111, 4'b1111, 1'b1, 8'h01);
    for (int c = 0; c < 2; c++) begin
      #1;
      check("rst.valid_o", 64'(valid_o), 64'd0);
      check("rst.ready_o", 64'(ready_o), 64'd0);
      check("rst.data_o", 64'(data_o), 64'd0);
      check("rst.last_o", 64'(last_o), 64'd0);
      check("rst.idx_o", 64'(idx_o), 64'd0);
      @(posedge clk_i);
      @(negedge clk_i);
    end
    rst_i = 1'b0;

    // No requests: deterministic zero outputs.
    drive(4'b0000, 4'b0000, 1'b1, 8'h02);
    #1;
    check("idle.valid_o", 64'(valid_o), 64'd0);
    check("idle.data_o", 64'(data_o), 64'd0);
    check("idle.idx_o", 64'(idx_o), 64'd0);
    cycle("idle");

    // Single-beat fairness: 0,1,2,3,0,1,2,3.
    for (int c = 0; c < 8; c++) begin
      drive(4'b1111, 4'b1111, 1'b1, 8'(16 + c));
      push(c % 4, 1'b1);
      cycle("fair");
    end

    // Packet lock: input 1 sends 3 beats while input 2 waits.
    drive(4'b0110, 4'b0000, 1'b1, 8'h21); push(1, 1'b0); cycle("lock.b1");
    drive(4'b0110, 4'b0000, 1'b1, 8'h22); push(1, 1'b0); cycle("lock.b2");
    drive(4'b0110, 4'b0010, 1'b1, 8'h23); push(1, 1'b1); cycle("lock.b3");
    drive(4'b0100, 4'b0100, 1'b1, 8'h24); push(2, 1'b1); cycle("lock.next");
    // Pointer now 3: input 3 beats inputs 0 and 1.
    drive(4'b1011, 4'b1011, 1'b1, 8'h25); push(3, 1'b1); cycle("lock.prio3");

    // Backpressure: grant and data held for 5 stalled cycles.
    drive(4'b0011, 4'b0011, 1'b0, 8'h40);
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp.valid_o", 64'(valid_o), 64'd1);
      check("bp.idx_o", 64'(idx_o), 64'd0);
      check("bp.data_o", 64'(data_o), 64'(lane_data(0, 8'h40)));
      cycle("bp.stall");
    end
    drive(4'b0011, 4'b0011, 1'b1, 8'h40); push(0, 1'b1); cycle("bp.release");
    drive(4'b0011, 4'b0011, 1'b1, 8'h41); push(1, 1'b1); cycle("bp.next");

    // Wrap-around: reach prio 3, then 0101 grants 0 then 2.
    drive(4'b0100, 4'b0100, 1'b1, 8'h50); push(2, 1'b1); cycle("wrap.setup");
    drive(4'b0101, 4'b0101, 1'b1, 8'h51); push(0, 1'b1); cycle("wrap.first");
    drive(4'b0101, 4'b0101, 1'b1, 8'h52); push(2, 1'b1); cycle("wrap.second");

    // Flush mid-packet: input 3 locked after one beat, flush restarts arbitration.
    drive(4'b1000, 4'b0000, 1'b1, 8'h60); push(3, 1'b0); cycle("flush.beat1");
    flush_i = 1'b1;
    drive(4'b1001, 4'b0000, 1'b1, 8'h61);
    #1;
    check("flush.valid_o", 64'(valid_o), 64'd0);
    cycle("flush.pulse");
    flush_i = 1'b0;
    drive(4'b1001, 4'b0001, 1'b1, 8'h62); push(0, 1'b1); cycle("flush.after");
    drive(4'b1000, 4'b0000, 1'b1, 8'h63); push(3, 1'b0); cycle("flush.b3");
    drive(4'b1000, 4'b1000, 1'b1, 8'h64); push(3, 1'b1); cycle("flush.b4");

    // Reset mid-packet while locked on input 2.
    drive(4'b0100, 4'b0000, 1'b1, 8'h70); push(2, 1'b0); cycle("rstm.beat1");
    rst_i = 1'b1;
    drive(4'b0111, 4'b0000, 1'b1, 8'h71);
    for (int c = 0; c < 2; c++) begin
      #1;
      check("rstm.valid_o", 64'(valid_o), 64'd0);
      cycle("rstm.hold");
    end
    rst_i = 1'b0;
    drive(4'b0111, 4'b0111, 1'b1, 8'h72); push(0, 1'b1); cycle("rstm.after");

    check("scoreboard.drain", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
